// File: rtl/alu_result_writeback_pkg.sv
// Shared encodings and fp32 <-> Q15 constants for the ALU write-back and operand paths.
// Q15 here means a 64-bit signed integer whose value is integer / 2^15.
package alu_wb_pkg;

  typedef enum logic [1:0] {
    DST_NONE = 2'b00,
    DST_GPR  = 2'b01,
    DST_XMM  = 2'b10,
    DST_PC   = 2'b11
  } dst_e;

  localparam int          Q15_FRAC_BITS     = 15;
  // fp32 mantissa carries 23 fraction bits; Q15 wants 15, hence 127 + 8.
  localparam logic [7:0]  FP32_BIAS_Q15     = 8'd135;
  localparam logic [63:0] Q15_SAT_POS       = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Q15_SAT_NEG       = 64'h8000_0000_0000_0000;
  localparam logic [7:0]  EXP_UNDERFLOW_MAX = 8'd111;
  localparam logic [7:0]  EXP_OVERFLOW_MIN  = 8'd175;
  localparam logic [7:0]  FP32_EXP_SPECIAL  = 8'hFF;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_SHIFT,
    WB_DONE
  } wb_state_e;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_SAT,
    FP_SHIFT
  } fp_kind_e;

  typedef struct packed {
    fp_kind_e   kind;
    logic       left;
    logic [6:0] amount;
  } fp_class_t;

  // Sorts an fp32 word into flush-to-zero, saturate, or a shift of the mantissa.
  function automatic fp_class_t fp32_classify(input logic [31:0] f);
    fp_class_t c;
    logic [7:0] e;
    e        = f[30:23];
    c.kind   = FP_SHIFT;
    c.left   = (e >= FP32_BIAS_Q15);
    c.amount = c.left ? 7'(e - FP32_BIAS_Q15) : 7'(FP32_BIAS_Q15 - e);
    if (e == 8'd0) begin
      c.kind = FP_ZERO;
    end else if (e == FP32_EXP_SPECIAL) begin
      c.kind = (f[22:0] != 23'd0) ? FP_ZERO : FP_SAT;
    end else if (e >= EXP_OVERFLOW_MIN) begin
      c.kind = FP_SAT;
    end else if (e <= EXP_UNDERFLOW_MAX) begin
      c.kind = FP_ZERO;
    end
    return c;
  endfunction

  function automatic logic fp32_needs_shift(input logic [31:0] f);
    fp_class_t c;
    c = fp32_classify(f);
    return (c.kind == FP_SHIFT) && (c.amount != 7'd0);
  endfunction

  function automatic logic [63:0] q15_apply_sign(input logic s, input logic [63:0] mag);
    return s ? (~mag + 64'd1) : mag;
  endfunction

endpackage

// File: rtl/alu_result_writeback_fp32_to_q15_seq.sv
// Multi-cycle fp32 -> signed 64-bit Q15 converter with an iterative barrel shifter.
// Specials and zero-shift values finish on the start edge; others shift SHIFT_STEP bits per cycle.
module fp32_to_q15_seq
  import alu_wb_pkg::*;
#(
  parameter int SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] fp32,
  output logic        finishing,
  output logic        done,
  output logic [63:0] q15
);

  localparam logic [6:0] STEP_W = 7'(SHIFT_STEP);

  logic        active_reg;
  logic        left_reg;
  logic        sign_reg;
  logic [6:0]  rem_reg;
  logic [63:0] mag_reg;
  logic        done_reg;
  logic [63:0] q15_reg;

  fp_class_t   start_class;
  logic [6:0]  step;
  logic [63:0] mag_next;
  logic [63:0] start_mag;

  assign start_class = fp32_classify(fp32);
  assign start_mag   = {40'd0, 1'b1, fp32[22:0]};
  assign step        = (rem_reg < STEP_W) ? rem_reg : STEP_W;
  assign mag_next    = left_reg ? (mag_reg << step) : (mag_reg >> step);
  // High in the last SHIFT cycle so the owner can move to DONE on the same edge.
  assign finishing   = active_reg && (rem_reg <= STEP_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      active_reg <= 1'b0;
      left_reg   <= 1'b0;
      sign_reg   <= 1'b0;
      rem_reg    <= 7'd0;
      mag_reg    <= 64'd0;
      done_reg   <= 1'b0;
      q15_reg    <= 64'd0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        sign_reg <= fp32[31];
        case (start_class.kind)
          FP_ZERO: begin
            done_reg <= 1'b1;
            q15_reg  <= 64'd0;
          end
          FP_SAT: begin
            done_reg <= 1'b1;
            q15_reg  <= fp32[31] ? Q15_SAT_NEG : Q15_SAT_POS;
          end
          default: begin
            if (start_class.amount == 7'd0) begin
              done_reg <= 1'b1;
              q15_reg  <= q15_apply_sign(fp32[31], start_mag);
            end else begin
              active_reg <= 1'b1;
              left_reg   <= start_class.left;
              rem_reg    <= start_class.amount;
              mag_reg    <= start_mag;
            end
          end
        endcase
      end else if (active_reg) begin
        mag_reg <= mag_next;
        rem_reg <= rem_reg - step;
        if (finishing) begin
          active_reg <= 1'b0;
          done_reg   <= 1'b1;
          q15_reg    <= q15_apply_sign(sign_reg, mag_next);
        end
      end
    end
  end

  assign done = done_reg;
  assign q15  = q15_reg;

endmodule

// File: rtl/alu_result_writeback.sv
// ALU write-back: routes a result to GPR, PC redirect or XMM (fp32 converted to Q15).
// Single-entry handshake: one result in flight, accepted only in IDLE.
module alu_result_writeback
  import alu_wb_pkg::*;
#(
  parameter int SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  dst,
  input  logic [31:0] result,
  output logic        gpr_wr_en,
  output logic [31:0] gpr_wr_data,
  output logic        pc_wr_en,
  output logic [31:0] pc_wr_data,
  output logic        xmm_wr_en,
  output logic [63:0] xmm_wr_data,
  output logic        busy
);

  wb_state_e   state_reg;
  logic        gpr_wr_en_reg;
  logic [31:0] gpr_wr_data_reg;
  logic        pc_wr_en_reg;
  logic [31:0] pc_wr_data_reg;

  logic        accept;
  logic        conv_start;
  logic        conv_finishing;

  assign accept     = in_valid && (state_reg == WB_IDLE);
  assign conv_start = accept && (dst == DST_XMM);

  fp32_to_q15_seq #(
    .SHIFT_STEP(SHIFT_STEP)
  ) u_conv (
    .clk      (clk),
    .reset    (reset),
    .start    (conv_start),
    .fp32     (result),
    .finishing(conv_finishing),
    .done     (xmm_wr_en),
    .q15      (xmm_wr_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= WB_IDLE;
      gpr_wr_en_reg   <= 1'b0;
      gpr_wr_data_reg <= 32'd0;
      pc_wr_en_reg    <= 1'b0;
      pc_wr_data_reg  <= 32'd0;
    end else begin
      case (state_reg)
        WB_IDLE: begin
          if (accept) begin
            state_reg <= WB_DONE;
            case (dst)
              DST_GPR: begin
                gpr_wr_en_reg   <= 1'b1;
                gpr_wr_data_reg <= result;
              end
              DST_PC: begin
                pc_wr_en_reg   <= 1'b1;
                pc_wr_data_reg <= result;
              end
              DST_XMM: begin
                if (fp32_needs_shift(result)) begin
                  state_reg <= WB_SHIFT;
                end
              end
              default: ;
            endcase
          end
        end
        WB_SHIFT: begin
          if (conv_finishing) begin
            state_reg <= WB_DONE;
          end
        end
        default: begin
          gpr_wr_en_reg <= 1'b0;
          pc_wr_en_reg  <= 1'b0;
          state_reg     <= WB_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (state_reg == WB_IDLE);
  assign busy        = (state_reg != WB_IDLE);
  assign gpr_wr_en   = gpr_wr_en_reg;
  assign gpr_wr_data = gpr_wr_data_reg;
  assign pc_wr_en    = pc_wr_en_reg;
  assign pc_wr_data  = pc_wr_data_reg;

endmodule

// File: tb/tb_alu_result_writeback.sv
// Self-checking bench for alu_result_writeback: directed vectors, routing, back-to-back,
// randomized results against a value-level model, and reset during a conversion.
module tb_alu_result_writeback;

  localparam int STEP = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  dst = 2'b00;
  logic [31:0] result = 32'd0;
  logic        gpr_wr_en;
  logic [31:0] gpr_wr_data;
  logic        pc_wr_en;
  logic [31:0] pc_wr_data;
  logic        xmm_wr_en;
  logic [63:0] xmm_wr_data;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_result_writeback #(.SHIFT_STEP(STEP)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dst        (dst),
    .result     (result),
    .gpr_wr_en  (gpr_wr_en),
    .gpr_wr_data(gpr_wr_data),
    .pc_wr_en   (pc_wr_en),
    .pc_wr_data (pc_wr_data),
    .xmm_wr_en  (xmm_wr_en),
    .xmm_wr_data(xmm_wr_data),
    .busy       (busy)
  );

  // Value-level model: Q15 value = m * 2^(e-135), with specials and truncation toward zero.
  function automatic void model_xmm(input logic [31:0] f, output logic [63:0] q, output int lat);
    int e;
    int sh;
    longint unsigned mag;
    e   = int'(f[30:23]);
    lat = 1;
    q   = 64'd0;
    if (e == 0 || (e == 255 && f[22:0] != 23'd0) || e <= 111) begin
      q = 64'd0;
    end else if (e >= 175) begin
      q = f[31] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    end else begin
      mag = {40'd0, 1'b1, f[22:0]};
      sh  = e - 135;
      if (sh >= 0) begin
        mag = mag << sh;
        lat = 1 + (sh + STEP - 1) / STEP;
      end else begin
        mag = mag >> (-sh);
        lat = 1 + ((-sh) + STEP - 1) / STEP;
      end
      q = f[31] ? (64'd0 - mag) : mag;
    end
  endfunction

  // Drives one accept from IDLE and watches until in_ready returns (no checking here).
  task automatic run_txn(input logic [1:0] d, input logic [31:0] r, output int lat,
                         output logic [63:0] data, output int n_gpr, output int n_pc,
                         output int n_xmm, output int busy_cycles);
    lat = 0; data = 64'd0; n_gpr = 0; n_pc = 0; n_xmm = 0; busy_cycles = 0;
    @(negedge clk);
    in_valid = 1'b1; dst = d; result = r;
    @(posedge clk); #1;
    in_valid = 1'b0; result = $urandom; dst = 2'($urandom);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (gpr_wr_en) begin n_gpr++; lat = c; data = {32'd0, gpr_wr_data}; end
      if (pc_wr_en)  begin n_pc++;  lat = c; data = {32'd0, pc_wr_data};  end
      if (xmm_wr_en) begin n_xmm++; lat = c; data = xmm_wr_data;          end
      if (in_ready) break;
      busy_cycles++;
      if (c == 40) busy_cycles = -1;
    end
    $display("txn dst=%0d result=%08h lat=%0d data=%016h busy=%0d", d, r, lat, data, busy_cycles);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, busy, gpr_wr_en, pc_wr_en, xmm_wr_en} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=10000", {in_ready, busy, gpr_wr_en, pc_wr_en, xmm_wr_en});
    end
    checks++;
    if ({gpr_wr_data, pc_wr_data, xmm_wr_data} !== 128'd0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {gpr_wr_data, pc_wr_data, xmm_wr_data});
    end
  endtask

  task automatic test_xmm_conversion();
    logic [31:0] vin [12] = '{32'h3F80_0000, 32'hC020_0000, 32'h4980_0000, 32'h7149_F2CA,
                              32'hFF80_0000, 32'h7FC0_0000, 32'h3000_0000, 32'h8000_0000,
                              32'h4380_0000, 32'h5700_0000, 32'h5780_0000, 32'h3800_0000};
    logic [63:0] vexp [12] = '{64'h0000_0000_0000_8000, 64'hFFFF_FFFF_FFFE_C000,
                               64'h0000_0008_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
                               64'h8000_0000_0000_0000, 64'h0, 64'h0, 64'h0,
                               64'h0000_0000_0080_0000, 64'h4000_0000_0000_0000,
                               64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001};
    int vlat [12] = '{2, 2, 3, 1, 1, 1, 1, 1, 1, 6, 1, 4};
    int lat, ng, np, nx, bc;
    logic [63:0] data;
    for (int i = 0; i < 12; i++) begin
      run_txn(2'b10, vin[i], lat, data, ng, np, nx, bc);
      checks++;
      if (data !== vexp[i]) begin
        failures++;
        $display("FAIL xmm_data[%0d] got=%h exp=%h", i, data, vexp[i]);
      end
      checks++;
      if (lat !== vlat[i] || bc !== vlat[i]) begin
        failures++;
        $display("FAIL xmm_latency[%0d] got=%0d busy=%0d exp=%0d", i, lat, bc, vlat[i]);
      end
      checks++;
      if (ng !== 0 || np !== 0 || nx !== 1) begin
        failures++;
        $display("FAIL xmm_strobes[%0d] got=%0d/%0d/%0d exp=0/0/1", i, ng, np, nx);
      end
    end
  endtask

  task automatic test_routing();
    int lat, ng, np, nx, bc;
    logic [63:0] data;
    run_txn(2'b01, 32'hDEAD_BEEF, lat, data, ng, np, nx, bc);
    checks++;
    if (data !== 64'hDEAD_BEEF || lat !== 1 || ng !== 1 || np !== 0 || nx !== 0) begin
      failures++;
      $display("FAIL gpr_route got=%h lat=%0d strobes=%0d/%0d/%0d exp=deadbeef lat=1 1/0/0", data, lat, ng, np, nx);
    end
    run_txn(2'b11, 32'h0000_0104, lat, data, ng, np, nx, bc);
    checks++;
    if (data !== 64'h104 || lat !== 1 || ng !== 0 || np !== 1 || nx !== 0) begin
      failures++;
      $display("FAIL pc_route got=%h lat=%0d strobes=%0d/%0d/%0d exp=104 lat=1 0/1/0", data, lat, ng, np, nx);
    end
    run_txn(2'b00, 32'h1234_5678, lat, data, ng, np, nx, bc);
    checks++;
    if (ng !== 0 || np !== 0 || nx !== 0 || bc !== 1) begin
      failures++;
      $display("FAIL none_route strobes=%0d/%0d/%0d busy=%0d exp=0/0/0 busy=1", ng, np, nx, bc);
    end
    checks++;
    if (gpr_wr_data !== 32'hDEAD_BEEF || pc_wr_data !== 32'h104) begin
      failures++;
      $display("FAIL data_hold got=%h/%h exp=deadbeef/00000104", gpr_wr_data, pc_wr_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  bd [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] br [3] = '{32'h3F80_0000, 32'hCAFE_0001, 32'h0000_0200};
    int acc_cyc [3] = '{-1, -1, -1};
    int xmm_cyc = -1, gpr_cyc = -1, pc_cyc = -1, n_str = 0, idx = 0;
    logic [63:0] xd = 64'd0;
    logic [31:0] gd = 32'd0, pd = 32'd0;
    logic acc;
    @(negedge clk);
    in_valid = 1'b1; dst = bd[0]; result = br[0];
    for (int c = 0; c < 12; c++) begin
      if (xmm_wr_en) begin xmm_cyc = c; xd = xmm_wr_data; n_str++; end
      if (gpr_wr_en) begin gpr_cyc = c; gd = gpr_wr_data; n_str++; end
      if (pc_wr_en)  begin pc_cyc = c;  pd = pc_wr_data;  n_str++; end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        acc_cyc[idx] = c;
        idx++;
        if (idx < 3) begin dst = bd[idx]; result = br[idx]; end
        else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    $display("txn back_to_back accepts=%0d,%0d,%0d strobes x=%0d g=%0d p=%0d", acc_cyc[0], acc_cyc[1], acc_cyc[2], xmm_cyc, gpr_cyc, pc_cyc);
    checks++;
    if (acc_cyc[0] !== 0 || acc_cyc[1] !== 3 || acc_cyc[2] !== 5) begin
      failures++;
      $display("FAIL b2b_accepts got=%0d,%0d,%0d exp=0,3,5", acc_cyc[0], acc_cyc[1], acc_cyc[2]);
    end
    checks++;
    if (xmm_cyc !== 2 || gpr_cyc !== 4 || pc_cyc !== 6 || n_str !== 3) begin
      failures++;
      $display("FAIL b2b_strobes got=%0d,%0d,%0d n=%0d exp=2,4,6 n=3", xmm_cyc, gpr_cyc, pc_cyc, n_str);
    end
    checks++;
    if (xd !== 64'h8000 || gd !== 32'hCAFE_0001 || pd !== 32'h200) begin
      failures++;
      $display("FAIL b2b_data got=%h/%h/%h exp=8000/cafe0001/200", xd, gd, pd);
    end
  endtask

  task automatic test_random();
    int lat, ng, np, nx, bc, exp_lat;
    logic [63:0] data, exp_data;
    logic [1:0] d;
    logic [31:0] r;
    for (int i = 0; i < 40; i++) begin
      d = 2'($urandom);
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[30:23] = 8'($urandom_range(105, 182));
      run_txn(d, r, lat, data, ng, np, nx, bc);
      exp_data = 64'd0; exp_lat = 1;
      if (d == 2'b10) model_xmm(r, exp_data, exp_lat);
      else if (d != 2'b00) exp_data = {32'd0, r};
      checks++;
      if (d == 2'b00) begin
        if (ng + np + nx !== 0 || bc !== 1) begin
          failures++;
          $display("FAIL rand_none[%0d] strobes=%0d busy=%0d exp=0 busy=1", i, ng + np + nx, bc);
        end
      end else if (data !== exp_data || lat !== exp_lat || bc !== exp_lat ||
                   ng !== int'(d == 2'b01) || np !== int'(d == 2'b11) || nx !== int'(d == 2'b10)) begin
        failures++;
        $display("FAIL rand_txn[%0d] dst=%0d in=%h got=%h lat=%0d exp=%h lat=%0d", i, d, r, data, lat, exp_data, exp_lat);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_x = 0;
    @(negedge clk);
    in_valid = 1'b1; dst = 2'b10; result = 32'h4980_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    if (xmm_wr_en) n_x++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, busy, gpr_wr_en, pc_wr_en, xmm_wr_en} !== 5'b10000 ||
        {gpr_wr_data, pc_wr_data, xmm_wr_data} !== 128'd0) begin
      failures++;
      $display("FAIL reset_mid_state ctrl=%b data=%h exp=10000 data=0", {in_ready, busy, gpr_wr_en, pc_wr_en, xmm_wr_en}, {gpr_wr_data, pc_wr_data, xmm_wr_data});
    end
    for (int c = 0; c < 6; c++) begin
      if (xmm_wr_en) n_x++;
      @(negedge clk);
    end
    $display("txn reset_mid xmm_strobes=%0d", n_x);
    checks++;
    if (n_x !== 0) begin
      failures++;
      $display("FAIL reset_mid_strobe got=%0d exp=0", n_x);
    end
  endtask

  initial begin
    test_reset();
    test_xmm_conversion();
    test_routing();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
